// File: rtl/spi_pkg.sv
// Constants and helpers shared by the SPI master and slave: byte width,
// bit-counter width, FSM encoding and the mode-0 clock polarity/phase.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam logic [SPI_CNT_W-1:0] SPI_LAST_BIT = SPI_CNT_W'(SPI_BYTE_W - 1);

    // Byte loaded into the tx shifter: buffered byte if present, else the filler.
    function automatic logic [SPI_BYTE_W-1:0] spi_tx_pick(
        input logic                  full,
        input logic [SPI_BYTE_W-1:0] data,
        input logic [SPI_BYTE_W-1:0] dflt
    );
        return full ? data : dflt;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with registered
// rise/fall pulses derived from the last two synchronised samples.
module spi_slave_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, with a one-deep tx buffer.
// Optional sticky underrun/overrun status under SPI_SLAVE_STATUS_EN.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned            SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] data_out,
    output logic                  new_data,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic                  status_clr,
    output logic                  underrun,
    output logic                  overrun,
`endif
    output logic                  busy
);

    logic sck_rise, sck_fall, sck_s_unused;
    logic ss_rise, ss_fall, ss_s_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sck (
        .clk(clk), .rst(rst), .din(sck),
        .dout(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss_n),
        .dout(ss_s_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // Sample on the leading edge and shift on the trailing edge in mode 0.
    logic sck_sample, sck_shift;
    assign sck_sample = (SPI_CPOL == SPI_CPHA) ? sck_rise : sck_fall;
    assign sck_shift  = (SPI_CPOL == SPI_CPHA) ? sck_fall : sck_rise;

    logic [0:0]            state, state_n;
    logic [SPI_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [SPI_BYTE_W-2:0] rx_shift, rx_shift_n;
    logic [SPI_BYTE_W-1:0] tx_shift, tx_shift_n;
    logic [SPI_BYTE_W-1:0] tx_buf, tx_buf_n;
    logic                  tx_ready_n;
    logic [SPI_BYTE_W-1:0] data_out_n;
    logic                  new_data_n;
    logic                  load;
    logic                  boundary;

    // Next-state: frame control, shifting, byte completion and tx buffer handshake.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_shift_n = rx_shift;
        tx_shift_n = tx_shift;
        tx_buf_n   = tx_buf;
        tx_ready_n = tx_ready;
        data_out_n = data_out;
        new_data_n = 1'b0;
        load       = 1'b0;
        boundary   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_n   = ST_ACTIVE;
                    bit_cnt_n = '0;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_n = ST_IDLE;
                end else if (sck_sample) begin
                    rx_shift_n = {rx_shift[SPI_BYTE_W-3:0], mosi_s};
                    bit_cnt_n  = bit_cnt + SPI_CNT_W'(1);
                    if (bit_cnt == SPI_LAST_BIT) begin
                        data_out_n = {rx_shift, mosi_s};
                        new_data_n = 1'b1;
                    end
                end else if (sck_shift) begin
                    if (bit_cnt == '0) begin
                        load     = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        tx_shift_n = {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A load in the same cycle as an accept sees the buffer still empty.
        if (load) begin
            tx_shift_n = spi_tx_pick(~tx_ready, tx_buf, DEFAULT_TX);
            tx_ready_n = 1'b1;
        end
        if (tx_valid && tx_ready) begin
            tx_buf_n   = tx_data;
            tx_ready_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
            data_out <= '0;
            new_data <= 1'b0;
            busy     <= 1'b0;
            miso_oe  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx_shift <= rx_shift_n;
            tx_shift <= tx_shift_n;
            tx_buf   <= tx_buf_n;
            tx_ready <= tx_ready_n;
            data_out <= data_out_n;
            new_data <= new_data_n;
            busy     <= (state_n == ST_ACTIVE);
            miso_oe  <= (state_n == ST_ACTIVE);
        end
    end

    assign miso = tx_shift[SPI_BYTE_W-1];

`ifdef SPI_SLAVE_STATUS_EN
    logic rx_pending;

    // Sticky flags; a set in the same cycle as status_clr takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            rx_pending <= 1'b0;
        end else begin
            if (status_clr) begin
                underrun   <= 1'b0;
                overrun    <= 1'b0;
                rx_pending <= 1'b0;
            end
            if (boundary && tx_ready) begin
                underrun <= 1'b1;
            end
            if (new_data_n) begin
                rx_pending <= 1'b1;
                if (rx_pending && !status_clr) begin
                    overrun <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed table, multi-cycle corner sequences and
// randomised frames checked against a byte-level model of the link.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst, sck, ss_n, mosi, miso, miso_oe;
    logic [7:0] tx_data, data_out;
    logic       tx_valid, tx_ready, new_data, busy;
`ifdef SPI_SLAVE_STATUS_EN
    logic       status_clr, underrun, overrun;
`endif

    int         checks   = 0;
    int         fails    = 0;
    int         nd_count = 0;
    int         half     = 8;
    logic [7:0] rx_q[$];
    logic [7:0] last_rx  = 8'h00;
    logic [7:0] mon_exp;

    spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .data_out(data_out), .new_data(new_data),
`ifdef SPI_SLAVE_STATUS_EN
        .status_clr(status_clr), .underrun(underrun), .overrun(overrun),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every new_data pulse must deliver the next byte the master completed.
    always @(negedge clk) begin
        if (rst === 1'b0 && new_data === 1'b1) begin
            nd_count++;
            if (rx_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_new_data: data_out %0h, no byte expected", data_out);
            end else begin
                mon_exp = rx_q.pop_front();
                check("rx_byte", 32'(data_out), 32'(mon_exp));
                last_rx = mon_exp;
            end
        end
    end

    task automatic send_tx(input logic [7:0] b);
        int n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL tx_handshake_timeout: tx_ready %b, required 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (half) @(negedge clk);
        ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Master side: drive nbits of b MSB first, capture miso just before each rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        logic [7:0] tmp = '0;
        if (nbits == 8) rx_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (half) @(negedge clk);
            tmp = {tmp[6:0], miso};
            sck = 1'b1;
            repeat (half) @(negedge clk);
            sck = 1'b0;
        end
        got = tmp;
    endtask

    typedef struct {
        logic [7:0] mosi_b;
        logic [7:0] tx_b;
        logic       pre;
        logic [7:0] exp_miso;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] got, got2;
    int         nd_before;
    logic       r_pre, r_abort;
    logic [7:0] r_tx, r_mb, r_exp;
    int         r_nb, r_bits, full_bytes;

    initial begin
        tbl[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 8'h3C};
        tbl[1] = '{8'h00, 8'h00, 1'b0, 8'hFF, 8'h00};
        tbl[2] = '{8'hFF, 8'h5A, 1'b1, 8'h5A, 8'hFF};
        tbl[3] = '{8'h96, 8'h00, 1'b1, 8'h00, 8'h96};

        rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state and idle with sck toggling
        check("reset_miso_oe", 32'(miso_oe), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_miso", 32'(miso), 32'd0);
        repeat (6) begin
            sck = ~sck;
            repeat (6) @(negedge clk);
        end
        sck = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_no_new_data", 32'(nd_count), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single-byte frames from the vector table
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].pre) begin
                send_tx(tbl[i].tx_b);
                check("tx_ready_after_offer", 32'(tx_ready), 32'd0);
            end
            nd_before = nd_count;
            frame_start();
            check("busy_in_frame", 32'(busy), 32'd1);
            check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
            check("tx_ready_after_load", 32'(tx_ready), 32'd1);
            spi_bits(tbl[i].mosi_b, 8, got);
            frame_end();
            check("tbl_miso", 32'(got), 32'(tbl[i].exp_miso));
            check("tbl_data_out", 32'(data_out), 32'(tbl[i].exp_data));
            check("tbl_one_pulse", 32'(nd_count - nd_before), 32'd1);
            check("idle_miso_oe", 32'(miso_oe), 32'd0);
        end

        // Empty buffer, two-byte frame
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
`endif
        frame_start();
        spi_bits(8'h01, 8, got);
        check("empty_byte1_data", 32'(data_out), 32'h01);
        spi_bits(8'h80, 8, got2);
        frame_end();
        check("empty_miso0", 32'(got), 32'hFF);
        check("empty_miso1", 32'(got2), 32'hFF);
        check("empty_data_out", 32'(data_out), 32'h80);
`ifdef SPI_SLAVE_STATUS_EN
        check("underrun_set", 32'(underrun), 32'd1);
`endif

        // Buffer refilled during the first byte
        send_tx(8'h11);
        frame_start();
        fork
            begin
                spi_bits(8'hA1, 8, got);
                spi_bits(8'hB2, 8, got2);
            end
            begin
                repeat (20) @(negedge clk);
                send_tx(8'h22);
            end
        join
        frame_end();
        check("refill_miso0", 32'(got), 32'h11);
        check("refill_miso1", 32'(got2), 32'h22);

        // Frame aborted after five bits, then a full frame
        nd_before = nd_count;
        frame_start();
        spi_bits(8'hE5, 5, got);
        frame_end();
        check("abort_no_pulse", 32'(nd_count - nd_before), 32'd0);
        check("abort_data_kept", 32'(data_out), 32'(last_rx));
        frame_start();
        spi_bits(8'hC3, 8, got);
        frame_end();
        check("after_abort_data", 32'(data_out), 32'hC3);
        check("after_abort_miso", 32'(got), 32'hFF);

        // Asynchronous reset in the middle of a byte
        frame_start();
        spi_bits(8'h77, 3, got);
        send_tx(8'hE7);
        sck = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_miso_oe", 32'(miso_oe), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_new_data", 32'(new_data), 32'd0);
        check("midrst_miso", 32'(miso), 32'd0);
        last_rx = 8'h00;
        sck = 1'b0;
        ss_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        frame_start();
        spi_bits(8'h5A, 8, got);
        frame_end();
        check("post_rst_data", 32'(data_out), 32'h5A);
        check("post_rst_miso", 32'(got), 32'hFF);

        // Randomised frames: buffered byte goes out first, then filler
        nd_before  = nd_count;
        full_bytes = 0;
        for (int f = 0; f < 20; f++) begin
            half    = $urandom_range(10, 4);
            r_pre   = 1'($urandom_range(1, 0));
            r_tx    = 8'($urandom);
            r_nb    = $urandom_range(3, 1);
            r_abort = ($urandom_range(3, 0) == 0);
            if (r_pre) send_tx(r_tx);
            frame_start();
            for (int k = 0; k < r_nb; k++) begin
                r_mb   = 8'($urandom);
                r_bits = (r_abort && k == r_nb - 1) ? $urandom_range(7, 1) : 8;
                spi_bits(r_mb, r_bits, got);
                if (r_bits == 8) begin
                    full_bytes++;
                    r_exp = (k == 0 && r_pre) ? r_tx : 8'hFF;
                    check("rand_miso", 32'(got), 32'(r_exp));
                end
            end
            frame_end();
            check("rand_tx_ready", 32'(tx_ready), 32'd1);
        end
        half = 8;
        repeat (20) @(negedge clk);
        check("rand_pulse_count", 32'(nd_count - nd_before), 32'(full_bytes));
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
